i2c_init_seq: RTL and testbench

Register-initialisation sequencer that sits directly upstream of the I2C master. On a start request it walks an external table of {reg_addr, data} entries and issues one single-mode write per entry to the master. Between writes it waits for the master's done pulse and checks the captured ACK status. It retries NACKed writes, executes inline delay entries and reports completion or failure to the system controller.

---
 rtl/i2c_init_seq_if.sv | 26 ++
 rtl/i2c_init_seq.sv | 201 ++++++++++++++++++++
 tb/tb_i2c_init_seq.sv | 301 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/i2c_init_seq_if.sv
// rtl/i2c_init_seq_if.sv - request/status bus between the init sequencer and the I2C master
interface i2c_init_seq_if #(
  parameter int ST_WIDTH = 4
);
  logic [6:0]          chip_addr;
  logic [7:0]          reg_addr;
  logic [15:0]         data_in;
  logic                write_en;
  logic                write_mode;
  logic                read_en;
  logic                m_busy;
  logic                m_done;
  logic [ST_WIDTH-1:0] m_status;

  // Sequencer side: issues write requests, observes master progress
  modport master (
    output chip_addr, reg_addr, data_in, write_en, write_mode, read_en,
    input  m_busy, m_done, m_status
  );

  // I2C master side
  modport slave (
    input  chip_addr, reg_addr, data_in, write_en, write_mode, read_en,
    output m_busy, m_done, m_status
  );
endinterface

// File: rtl/i2c_init_seq.sv
// rtl/i2c_init_seq.sv - table-driven I2C register initialisation sequencer
module i2c_init_seq #(
  parameter logic [6:0] CHIP_ADDR   = 7'h3C,
  parameter int         NUM_ENTRIES = 40,
  parameter int         TBL_AW      = 6,
  parameter int         ST_WIDTH    = 4,
  parameter int         MAX_RETRY   = 3,
  parameter int         RETRY_GAP   = 1000,
  parameter int         DELAY_UNIT  = 50000,
  parameter int         TIMEOUT     = 200000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic [TBL_AW-1:0] tbl_addr,
  input  logic [23:0]       tbl_data,
  i2c_init_seq_if.master    bus,
  output logic              seq_busy,
  output logic              seq_done,
  output logic              seq_err,
  output logic [TBL_AW-1:0] err_idx,
  output logic [1:0]        err_code
);

  localparam int                RW        = $clog2(MAX_RETRY + 1) + 1;
  localparam logic [31:0]       GAP_LAST  = 32'(RETRY_GAP - 1);
  localparam logic [31:0]       TMO_LAST  = 32'(TIMEOUT - 1);
  localparam logic [TBL_AW-1:0] LAST_IDX  = TBL_AW'(NUM_ENTRIES - 1);
  localparam logic [RW-1:0]     RETRY_MAX = RW'(MAX_RETRY);

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_DECODE, S_ISSUE, S_WAIT, S_CHECK, S_GAP, S_DELAY, S_FINISH
  } state_t;

  state_t              state, state_n;
  logic [TBL_AW-1:0]   index, index_n;
  logic [TBL_AW-1:0]   tbl_addr_n, err_idx_n;
  logic [RW-1:0]       retry, retry_n;
  logic [31:0]         cnt, cnt_n;
  logic [7:0]          ra_q, ra_n;
  logic [15:0]         wd_q, wd_n;
  logic                we_q, we_n;
  logic                busy_n, done_n, err_n;
  logic [1:0]          code_n;
  logic [31:0]         delay_load;
  logic [ST_WIDTH-1:0] status;
  logic                nack;
  logic                advance;

  // Delay ticks are scaled to clk cycles in 32 bits so the largest entry never wraps
  assign delay_load = 32'(tbl_data[15:0]) * 32'(DELAY_UNIT);
  assign status     = bus.m_status;
  assign nack       = |status;

  assign bus.chip_addr  = CHIP_ADDR;
  assign bus.write_mode = 1'b0;
  assign bus.read_en    = 1'b0;
  assign bus.write_en   = we_q;
  assign bus.reg_addr   = ra_q;
  assign bus.data_in    = wd_q;

  // State and registered outputs; reset drops everything, including an in-flight write_en
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      index    <= '0;
      retry    <= '0;
      cnt      <= '0;
      tbl_addr <= '0;
      ra_q     <= '0;
      wd_q     <= '0;
      we_q     <= 1'b0;
      seq_busy <= 1'b0;
      seq_done <= 1'b0;
      seq_err  <= 1'b0;
      err_idx  <= '0;
      err_code <= 2'b00;
    end else begin
      state    <= state_n;
      index    <= index_n;
      retry    <= retry_n;
      cnt      <= cnt_n;
      tbl_addr <= tbl_addr_n;
      ra_q     <= ra_n;
      wd_q     <= wd_n;
      we_q     <= we_n;
      seq_busy <= busy_n;
      seq_done <= done_n;
      seq_err  <= err_n;
      err_idx  <= err_idx_n;
      err_code <= code_n;
    end
  end

  // Next-state and next-output logic; write_en and seq_done are single-cycle by default
  always_comb begin
    state_n    = state;
    index_n    = index;
    retry_n    = retry;
    cnt_n      = cnt;
    tbl_addr_n = tbl_addr;
    ra_n       = ra_q;
    wd_n       = wd_q;
    we_n       = 1'b0;
    busy_n     = seq_busy;
    done_n     = 1'b0;
    err_n      = seq_err;
    err_idx_n  = err_idx;
    code_n     = err_code;
    advance    = 1'b0;

    case (state)
      S_IDLE: begin
        if (start) begin
          err_n      = 1'b0;
          code_n     = 2'b00;
          index_n    = '0;
          retry_n    = '0;
          busy_n     = 1'b1;
          tbl_addr_n = '0;
          state_n    = S_FETCH;
        end
      end
      S_FETCH: state_n = S_DECODE;
      S_DECODE: begin
        if (tbl_data[23:16] == 8'hFF) begin
          if (delay_load == 32'd0) begin
            advance = 1'b1;
          end else begin
            cnt_n   = delay_load;
            state_n = S_DELAY;
          end
        end else begin
          ra_n    = tbl_data[23:16];
          wd_n    = tbl_data[15:0];
          state_n = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (!bus.m_busy) begin
          we_n    = 1'b1;
          cnt_n   = '0;
          state_n = S_WAIT;
        end
      end
      S_WAIT: begin
        if (bus.m_done) begin
          state_n = S_CHECK;
        end else if (cnt >= TMO_LAST) begin
          err_n     = 1'b1;
          code_n    = 2'b10;
          err_idx_n = index;
          busy_n    = 1'b0;
          state_n   = S_FINISH;
        end else begin
          cnt_n = cnt + 32'd1;
        end
      end
      S_CHECK: begin
        if (!nack) begin
          retry_n = '0;
          advance = 1'b1;
        end else if (retry < RETRY_MAX) begin
          retry_n = retry + RW'(1);
          cnt_n   = '0;
          state_n = S_GAP;
        end else begin
          err_n     = 1'b1;
          code_n    = 2'b01;
          err_idx_n = index;
          busy_n    = 1'b0;
          state_n   = S_FINISH;
        end
      end
      S_GAP: begin
        if (cnt >= GAP_LAST) state_n = S_ISSUE;
        else                 cnt_n   = cnt + 32'd1;
      end
      S_DELAY: begin
        if (cnt == 32'd0) advance = 1'b1;
        else              cnt_n   = cnt - 32'd1;
      end
      S_FINISH: state_n = S_IDLE;
      default:  state_n = S_IDLE;
    endcase

    // Move to the next entry, or close the sequence after the last one
    if (advance) begin
      if (index == LAST_IDX) begin
        busy_n  = 1'b0;
        done_n  = ~seq_err;
        state_n = S_FINISH;
      end else begin
        index_n    = index + TBL_AW'(1);
        tbl_addr_n = index + TBL_AW'(1);
        state_n    = S_FETCH;
      end
    end
  end

endmodule

// File: tb/tb_i2c_init_seq.sv
// tb/tb_i2c_init_seq.sv - self-checking bench for the I2C init sequencer
module tb_i2c_init_seq;
  localparam int NUM_ENTRIES = 4;
  localparam int TBL_AW      = 6;
  localparam int ST_WIDTH    = 4;
  localparam int MAX_RETRY   = 3;
  localparam int RETRY_GAP   = 20;
  localparam int DELAY_UNIT  = 10;
  localparam int TIMEOUT     = 100;
  localparam int DONE_LAT    = 50;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic [TBL_AW-1:0] tbl_addr;
  logic [23:0]       tbl_data;
  logic              seq_busy, seq_done, seq_err;
  logic [TBL_AW-1:0] err_idx;
  logic [1:0]        err_code;

  i2c_init_seq_if #(.ST_WIDTH(ST_WIDTH)) bus ();

  i2c_init_seq #(
    .CHIP_ADDR(7'h3C), .NUM_ENTRIES(NUM_ENTRIES), .TBL_AW(TBL_AW), .ST_WIDTH(ST_WIDTH),
    .MAX_RETRY(MAX_RETRY), .RETRY_GAP(RETRY_GAP), .DELAY_UNIT(DELAY_UNIT), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .tbl_addr(tbl_addr), .tbl_data(tbl_data),
    .bus(bus), .seq_busy(seq_busy), .seq_done(seq_done), .seq_err(seq_err),
    .err_idx(err_idx), .err_code(err_code)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", nm, act, req);
    end
  endtask

  // Table ROM with one clock of read latency
  logic [23:0] tbl [0:63];
  logic [TBL_AW-1:0] tbl_a;
  always begin
    @(negedge clk);
    tbl_a = tbl_addr;
    @(posedge clk);
    #1;
    tbl_data = tbl[tbl_a];
  end

  // I2C master model: busy after a write, done DONE_LAT cycles later with a scripted status
  logic [3:0] script [0:15];
  bit         no_done;
  int         mcnt;
  int         sp;
  always begin
    @(posedge clk);
    #1;
    bus.m_done = 1'b0;
    if (!seq_busy) sp = 0;
    if (reset) begin
      bus.m_busy   = 1'b0;
      bus.m_status = '0;
      mcnt         = 0;
    end else if (bus.write_en) begin
      bus.m_busy = 1'b1;
      mcnt       = DONE_LAT;
    end else if (mcnt > 0) begin
      mcnt--;
      if (mcnt == 0) begin
        bus.m_busy = 1'b0;
        if (!no_done) begin
          bus.m_done   = 1'b1;
          bus.m_status = script[sp];
          sp++;
        end
      end
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: expected writes in order, with the minimum idle gap before each
  typedef struct {
    logic [7:0]  ra;
    logic [15:0] d;
    int          mingap;
  } wr_t;
  wr_t               exp_q[$];
  bit                exp_ok;
  logic [1:0]        exp_code;
  logic [TBL_AW-1:0] exp_idx;

  task automatic build_model();
    int s = 0;
    int gap = 0;
    exp_q.delete();
    exp_ok = 1'b1; exp_code = 2'b00; exp_idx = '0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      logic [23:0] e;
      e = tbl[i];
      if (e[23:16] == 8'hFF) begin
        gap += int'(e[15:0]) * DELAY_UNIT;
        continue;
      end
      for (int a = 0; a <= MAX_RETRY; a++) begin
        wr_t w;
        w.ra = e[23:16];
        w.d  = e[15:0];
        w.mingap = (a == 0) ? gap : RETRY_GAP;
        exp_q.push_back(w);
        gap = 0;
        if (no_done) begin
          exp_ok = 1'b0; exp_code = 2'b10; exp_idx = TBL_AW'(i);
          return;
        end
        if (script[s] == 4'b0000) break;
        s++;
        if (a == MAX_RETRY) begin
          exp_ok = 1'b0; exp_code = 2'b01; exp_idx = TBL_AW'(i);
          return;
        end
      end
      s += 0;
      if (script[s] == 4'b0000) s++;
    end
  endtask

  // Per-cycle compare against the model
  int start_cyc, last_done, last_we;
  int done_cnt = 0;
  bit prev_we, prev_err, first_flag;
  always @(negedge clk) begin
    wr_t w;
    if (reset) begin
      prev_we = 1'b0; prev_err = 1'b0; first_flag = 1'b0;
      exp_q.delete();
    end else begin
      if (start && !seq_busy && !seq_done) begin
        start_cyc  = cyc;
        first_flag = 1'b1;
      end
      if (bus.m_done) last_done = cyc;
      if (bus.write_en) begin
        chk("write_en_single_cycle", {31'd0, prev_we}, 32'd0);
        if (exp_q.size() == 0) begin
          chk("unexpected_write", 32'd1, 32'd0);
        end else begin
          w = exp_q.pop_front();
          chk("reg_addr", {24'd0, bus.reg_addr}, {24'd0, w.ra});
          chk("data_in", {16'd0, bus.data_in}, {16'd0, w.d});
          chk("chip_addr", {25'd0, bus.chip_addr}, 32'h3C);
          chk("mode_rd_tied", {30'd0, bus.write_mode, bus.read_en}, 32'd0);
          if (first_flag) begin
            chk("first_write_latency", cyc - start_cyc, 32'd4);
            first_flag = 1'b0;
          end else if (w.mingap > 0) begin
            chk("min_gap_before_write", {31'd0, (cyc - last_done) >= w.mingap}, 32'd1);
          end
        end
        last_we = cyc;
      end
      prev_we = bus.write_en;
      if (seq_done) begin
        done_cnt++;
        chk("done_when_model_ok", {31'd0, exp_ok}, 32'd1);
        chk("done_without_err", {31'd0, seq_err}, 32'd0);
        chk("done_all_writes_seen", exp_q.size(), 32'd0);
      end
      if (seq_err && !prev_err) begin
        chk("err_code", {30'd0, err_code}, {30'd0, exp_code});
        chk("err_idx", {26'd0, err_idx}, {26'd0, exp_idx});
        if (exp_code == 2'b10) chk("timeout_cycles", cyc - last_we, TIMEOUT);
      end
      prev_err = seq_err;
    end
  end

  // mode 0: plain, 1: start during the FINISH cycle, 2: start mid-sequence
  task automatic run(input int mode);
    int d0;
    d0 = done_cnt;
    @(posedge clk); #1; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    @(negedge clk);
    chk("busy_after_start", {31'd0, seq_busy}, 32'd1);
    chk("err_cleared_by_start", {31'd0, seq_err}, 32'd0);
    for (int k = 0; k < 5000 && seq_busy; k++) begin
      @(negedge clk);
      if ((mode == 1 && seq_done) || (mode == 2 && k == 20)) begin
        start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
      end
    end
    chk("sequence_ended", {31'd0, seq_busy}, 32'd0);
    repeat (10) @(negedge clk);
    chk("still_idle", {31'd0, seq_busy}, 32'd0);
    chk("done_pulse_count", done_cnt - d0, exp_ok ? 32'd1 : 32'd0);
    chk("err_flag", {31'd0, seq_err}, {31'd0, !exp_ok});
    if (!exp_ok) begin
      chk("err_code_final", {30'd0, err_code}, {30'd0, exp_code});
      chk("err_idx_final", {26'd0, err_idx}, {26'd0, exp_idx});
    end
    chk("writes_consumed", exp_q.size(), 32'd0);
  endtask

  task automatic check_reset_vals();
    chk("rst_write_en", {31'd0, bus.write_en}, 32'd0);
    chk("rst_seq_busy", {31'd0, seq_busy}, 32'd0);
    chk("rst_seq_done", {31'd0, seq_done}, 32'd0);
    chk("rst_seq_err", {31'd0, seq_err}, 32'd0);
    chk("rst_err_code", {30'd0, err_code}, 32'd0);
    chk("rst_err_idx", {26'd0, err_idx}, 32'd0);
    chk("rst_tbl_addr", {26'd0, tbl_addr}, 32'd0);
    chk("rst_reg_addr", {24'd0, bus.reg_addr}, 32'd0);
    chk("rst_data_in", {16'd0, bus.data_in}, 32'd0);
  endtask

  task automatic load_t1();
    tbl[0] = 24'h101234; tbl[1] = 24'h11ABCD; tbl[2] = 24'h120001; tbl[3] = 24'h135A5A;
  endtask

  task automatic clear_script();
    for (int i = 0; i < 16; i++) script[i] = 4'b0000;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; start = 1'b0; no_done = 1'b0;
    for (int i = 0; i < 64; i++) tbl[i] = 24'h0;
    clear_script();
    repeat (3) @(negedge clk);
    check_reset_vals();
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // All ACKed; a start in the FINISH cycle must be ignored
    load_t1();
    build_model();
    chk("model_t1_writes", exp_q.size(), 32'd4);
    run(1);

    // Entry 1 NACKed twice then ACKed
    script[1] = 4'b0010; script[2] = 4'b0010;
    build_model();
    chk("model_t2_writes", exp_q.size(), 32'd6);
    run(0);

    // Master never finishes: timeout on entry 0, extra start ignored
    clear_script();
    no_done = 1'b1;
    build_model();
    chk("model_t5_code", {30'd0, exp_code}, 32'd2);
    run(2);
    no_done = 1'b0;

    // Entry 2 NACKed on every attempt
    script[2] = 4'b0010; script[3] = 4'b0010; script[4] = 4'b0010; script[5] = 4'b0010;
    build_model();
    chk("model_t3_writes", exp_q.size(), 32'd6);
    chk("model_t3_idx", {26'd0, exp_idx}, 32'd2);
    run(0);

    // Delay entry between writes, zero-length delay as the last entry
    clear_script();
    tbl[0] = 24'h201111; tbl[1] = 24'hFF0003; tbl[2] = 24'h212222; tbl[3] = 24'hFF0000;
    build_model();
    chk("model_t4_writes", exp_q.size(), 32'd2);
    chk("model_t4_gap", exp_q[1].mingap, 32'd30);
    run(0);

    // Reset while write_en is high, then restart from entry 0
    load_t1();
    build_model();
    @(posedge clk); #1; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    for (int k = 0; k < 100 && !bus.write_en; k++) @(negedge clk);
    chk("write_seen_before_reset", {31'd0, bus.write_en}, 32'd1);
    #2 reset = 1'b1;
    #1 check_reset_vals();
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    build_model();
    run(0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
